// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and step-count helper for alu_seq.
// Optional OVERFLOW output is enabled with ALU_SEQ_OVERFLOW_EN.
package alu_seq_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_FWD = 4'b0000;
  localparam op_t OP_ADD = 4'b0001;
  localparam op_t OP_AND = 4'b0010;
  localparam op_t OP_OR  = 4'b0011;
  localparam op_t OP_SUB = 4'b0100;
  localparam op_t OP_XOR = 4'b0101;
  localparam op_t OP_SLL = 4'b0110;
  localparam op_t OP_SRL = 4'b0111;
  localparam op_t OP_SRA = 4'b1000;
  localparam op_t OP_ROR = 4'b1001;
  localparam op_t OP_MUL = 4'b1010;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  // Zero for every single-cycle op, so S != 0 also marks an iterative op.
  function automatic int unsigned step_count(
    input op_t         op,
    input int unsigned amt,
    input int unsigned w
  );
    unique case (op)
      OP_SLL, OP_SRL, OP_SRA: step_count = (amt < w) ? amt : w;
      OP_ROR:                 step_count = amt % w;
      OP_MUL:                 step_count = w;
      default:                step_count = 0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// START/BUSY/DONE handshake bundle between the control unit and alu_seq.
// OVERFLOW exists only when ALU_SEQ_OVERFLOW_EN is defined.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  import alu_seq_pkg::*;

  logic             START;
  op_t              ALU_OP;
  logic [WIDTH-1:0] OPERAND1;
  logic [WIDTH-1:0] OPERAND2;
  logic [WIDTH-1:0] ALU_RESULT;
  logic             ZERO;
  logic             BUSY;
  logic             DONE;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic             OVERFLOW;
`endif

  modport master (
    output START, ALU_OP, OPERAND1, OPERAND2,
`ifdef ALU_SEQ_OVERFLOW_EN
    input  OVERFLOW,
`endif
    input  ALU_RESULT, ZERO, BUSY, DONE
  );

  modport slave (
    input  START, ALU_OP, OPERAND1, OPERAND2,
`ifdef ALU_SEQ_OVERFLOW_EN
    output OVERFLOW,
`endif
    output ALU_RESULT, ZERO, BUSY, DONE
  );

endinterface

// File: rtl/alu_seq_iter.sv
// Iterative datapath: shift/rotate register, shift-add multiplier, step counter.
// ALU_SEQ_OVERFLOW_EN widens the multiply accumulator to 2*WIDTH.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    steps,
`ifdef ALU_SEQ_OVERFLOW_EN
  output logic             ovf_next,
`endif
  output logic             last,
  output logic [WIDTH-1:0] res_next
);

`ifdef ALU_SEQ_OVERFLOW_EN
  localparam int AW = 2 * WIDTH;
`else
  localparam int AW = WIDTH;
`endif

  op_t              op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_nxt;
  logic [AW-1:0]    mc;

  // For MUL, sh holds the multiplier and is consumed LSB first.
  always_comb begin
    sh_nxt = sh;
    unique case (op_q)
      OP_SLL:  sh_nxt = sh << 1;
      OP_SRL:  sh_nxt = sh >> 1;
      OP_SRA:  sh_nxt = {sh[WIDTH-1], sh[WIDTH-1:1]};
      OP_ROR:  sh_nxt = {sh[0], sh[WIDTH-1:1]};
      OP_MUL:  sh_nxt = sh >> 1;
      default: sh_nxt = sh;
    endcase
    acc_nxt  = sh[0] ? acc + mc : acc;
    res_next = (op_q == OP_MUL) ? acc_nxt[WIDTH-1:0] : sh_nxt;
  end

`ifdef ALU_SEQ_OVERFLOW_EN
  assign ovf_next = |acc_nxt[AW-1:WIDTH];
`endif

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= OP_FWD;
      cnt  <= '0;
      sh   <= '0;
      acc  <= '0;
      mc   <= '0;
    end else if (load) begin
      op_q <= op;
      cnt  <= steps;
      acc  <= '0;
      mc   <= AW'(a);
      sh   <= (op == OP_MUL) ? b : a;
    end else if (step) begin
      cnt  <= cnt - CW'(1);
      sh   <= sh_nxt;
      acc  <= acc_nxt;
      mc   <= mc << 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle logic/arith ops plus iterative shifts and multiply.
// Define ALU_SEQ_OVERFLOW_EN to add the registered OVERFLOW output.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  alu_seq_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             done_q;
  logic [WIDTH-1:0] res1;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    steps;
  int unsigned      s;
  logic             accept;
  logic             iter_go;
  logic             last;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic             ovf_q;
  logic             ovf1;
  logic             ovf_next;
`endif

  assign sum     = bus.OPERAND1 + bus.OPERAND2;
  assign diff    = bus.OPERAND1 - bus.OPERAND2;
  assign s       = step_count(bus.ALU_OP, 32'(bus.OPERAND2), WIDTH);
  assign steps   = CW'(s);
  assign accept  = (state == IDLE) && bus.START;
  assign iter_go = accept && (steps != '0);

  // Iterative ops with zero steps fall through here and return OPERAND1.
  always_comb begin
    res1 = '0;
    unique case (bus.ALU_OP)
      OP_FWD:  res1 = bus.OPERAND2;
      OP_ADD:  res1 = sum;
      OP_AND:  res1 = bus.OPERAND1 & bus.OPERAND2;
      OP_OR:   res1 = bus.OPERAND1 | bus.OPERAND2;
      OP_SUB:  res1 = diff;
      OP_XOR:  res1 = bus.OPERAND1 ^ bus.OPERAND2;
      OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_MUL:
               res1 = bus.OPERAND1;
      default: res1 = '0;
    endcase
  end

`ifdef ALU_SEQ_OVERFLOW_EN
  always_comb begin
    ovf1 = 1'b0;
    unique case (1'b1)
      bus.ALU_OP == OP_ADD:
        ovf1 = (bus.OPERAND1[WIDTH-1] == bus.OPERAND2[WIDTH-1])
            && (sum[WIDTH-1] != bus.OPERAND1[WIDTH-1]);
      bus.ALU_OP == OP_SUB:
        ovf1 = (bus.OPERAND1[WIDTH-1] != bus.OPERAND2[WIDTH-1])
            && (diff[WIDTH-1] != bus.OPERAND1[WIDTH-1]);
      default: ovf1 = 1'b0;
    endcase
  end
`endif

  alu_seq_iter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iter (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (iter_go),
    .step     (state == RUN),
    .op       (bus.ALU_OP),
    .a        (bus.OPERAND1),
    .b        (bus.OPERAND2),
    .steps    (steps),
`ifdef ALU_SEQ_OVERFLOW_EN
    .ovf_next (ovf_next),
`endif
    .last     (last),
    .res_next (res_next)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iter_go) begin
            state <= RUN;
          end else if (accept) begin
            result_q <= res1;
            zero_q   <= (res1 == '0);
            done_q   <= 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
            ovf_q    <= ovf1;
`endif
          end
        end
        RUN: begin
          if (last) begin
            state    <= IDLE;
            result_q <= res_next;
            zero_q   <= (res_next == '0);
            done_q   <= 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
            ovf_q    <= ovf_next;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ALU_RESULT = result_q;
  assign bus.ZERO       = zero_q;
  assign bus.DONE       = done_q;
  assign bus.BUSY       = (state == RUN);
`ifdef ALU_SEQ_OVERFLOW_EN
  assign bus.OVERFLOW   = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8); expected results queued at issue.
// Define ALU_SEQ_OVERFLOW_EN to also check OVERFLOW.
module tb_alu_seq;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic       ovf;
    int         steps;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  alu_seq_if #(.WIDTH(8)) bus();

  alu_seq #(.WIDTH(8)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, output logic [7:0] r,
                       output logic o, output int s);
    logic [15:0]       p;
    logic signed [7:0] t;
    int                sum;
    int                k;
    r = '0;
    o = 1'b0;
    s = 0;
    case (op)
      4'd0: r = b;
      4'd1: begin
        r   = a + b;
        sum = int'($signed(a)) + int'($signed(b));
        o   = (sum > 127) || (sum < -128);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: begin
        r   = a - b;
        sum = int'($signed(a)) - int'($signed(b));
        o   = (sum > 127) || (sum < -128);
      end
      4'd5: r = a ^ b;
      4'd6, 4'd7, 4'd8: begin
        s = (int'(b) < 8) ? int'(b) : 8;
        if (int'(b) >= 8) r = (op == 4'd8) ? {8{a[7]}} : 8'h00;
        else if (op == 4'd6) r = a << b;
        else if (op == 4'd7) r = a >> b;
        else begin
          t = $signed(a);
          t = t >>> b;
          r = t;
        end
      end
      4'd9: begin
        k = int'(b) % 8;
        s = k;
        r = (a >> k) | (a << (8 - k));
      end
      4'd10: begin
        p = 16'(a) * 16'(b);
        r = p[7:0];
        o = |p[15:8];
        s = 8;
      end
      default: r = 8'h00;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.BUSY) busy_cnt++;
    if (!rst_n) busy_cnt = 0;
    if (bus.DONE) begin
      if (q.size() == 0) begin
        check("spurious_done", 32'(bus.ALU_RESULT), 32'hDEAD);
      end else begin
        e = q.pop_front();
        check({e.tag, ".res"}, 32'(bus.ALU_RESULT), 32'(e.res));
        check({e.tag, ".zero"}, 32'(bus.ZERO), 32'(e.res == 8'h00));
        check({e.tag, ".lat"}, cyc, e.done_cyc);
        check({e.tag, ".busy"}, busy_cnt, e.steps);
`ifdef ALU_SEQ_OVERFLOW_EN
        check({e.tag, ".ovf"}, 32'(bus.OVERFLOW), 32'(e.ovf));
`endif
      end
      busy_cnt = 0;
    end
  end

  task automatic issue(input string tag, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    model(op, a, b, e.res, e.ovf, e.steps);
    e.tag      = tag;
    e.done_cyc = cyc + 1 + e.steps;
    q.push_back(e);
    bus.START    = 1'b1;
    bus.ALU_OP   = op;
    bus.OPERAND1 = a;
    bus.OPERAND2 = b;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      check("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] want);
    issue(tag, op, a, b);
    wait_idle();
    check({tag, ".const"}, 32'(bus.ALU_RESULT), 32'(want));
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         n;
    rst_n        = 1'b0;
    bus.START    = 1'b0;
    bus.ALU_OP   = 4'h0;
    bus.OPERAND1 = 8'h00;
    bus.OPERAND2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst.res", 32'(bus.ALU_RESULT), 0);
    check("rst.zero", 32'(bus.ZERO), 1);
    check("rst.busy", 32'(bus.BUSY), 0);
    check("rst.done", 32'(bus.DONE), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("add", 4'b0001, 8'hF0, 8'h20, 8'h10);
    run("sub", 4'b0100, 8'h05, 8'h05, 8'h00);
    run("op15", 4'b1111, 8'h33, 8'h44, 8'h00);
    run("sll", 4'b0110, 8'h81, 8'd3, 8'h08);
    run("sra", 4'b1000, 8'h80, 8'd9, 8'hFF);
    run("ror", 4'b1001, 8'h01, 8'd9, 8'h80);
    run("srl0", 4'b0111, 8'h5A, 8'd0, 8'h5A);
    run("mul", 4'b1010, 8'd13, 8'd11, 8'h8F);
`ifdef ALU_SEQ_OVERFLOW_EN
    run("mulovf", 4'b1010, 8'd16, 8'd16, 8'h00);
    check("mulovf.flag", 32'(bus.OVERFLOW), 1);
    run("addovf", 4'b0001, 8'h7F, 8'h01, 8'h80);
    check("addovf.flag", 32'(bus.OVERFLOW), 1);
`endif

    issue("b2b_fwd", 4'b0000, 8'h00, 8'h11);
    issue("b2b_and", 4'b0010, 8'hF0, 8'h3C);
    issue("b2b_or", 4'b0011, 8'h0F, 8'h30);
    issue("b2b_xor", 4'b0101, 8'hFF, 8'h0F);
    wait_idle();

    issue("mul_ign", 4'b1010, 8'd3, 8'd5);
    bus.START    = 1'b1;
    bus.ALU_OP   = 4'b0001;
    bus.OPERAND1 = 8'hFF;
    bus.OPERAND2 = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    bus.START = 1'b0;
    n = 0;
    while (!bus.DONE && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mul_ign.done_seen", 32'(bus.DONE), 1);
    check("mul_ign.res", 32'(bus.ALU_RESULT), 32'h0F);
    issue("fwd_in_done", 4'b0000, 8'h00, 8'h3C);
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom_range(0, 255));
      b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                       : 8'($urandom_range(0, 255));
      issue($sformatf("rnd%0d", i), op, a, b);
      wait_idle();
    end

    run("pre_abort", 4'b0000, 8'h00, 8'hA5, 8'hA5);
    issue("abort_mul", 4'b1010, 8'd7, 8'd9);
    repeat (3) @(posedge clk);
    #1;
    void'(q.pop_back());
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort.busy", 32'(bus.BUSY), 0);
    check("abort.res", 32'(bus.ALU_RESULT), 0);
    check("abort.zero", 32'(bus.ZERO), 1);
    repeat (15) @(posedge clk);
    #1;
    run("post_abort", 4'b0001, 8'h01, 8'h02, 8'h03);
    check("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the 8-bit combinational CPU ALU.
- Single-cycle ops: FWD, ADD, SUB, AND, OR, XOR.
- Iterative multi-cycle ops: logical and arithmetic shifts, rotate, and a shift-add multiply.
- Uses a START/BUSY/DONE handshake so the CPU control unit can stall on long ops.
- ZERO is registered with the result and replaces the old combinational COMPARATOR for branch decisions.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- CLK  input  1  single clock; all state updates on rising edge
- RESET  input  1  synchronous reset, active-low
- START  input  1  request; sampled only when BUSY=0
- ALU_OP  input  4  operation select, latched on accept
- OPERAND1  input  WIDTH  first operand, latched on accept
- OPERAND2  input  WIDTH  second operand / shift amount, latched on accept
- ALU_RESULT  output  WIDTH  registered result; holds until the next completion
- ZERO  output  1  registered; 1 when ALU_RESULT == 0
- BUSY  output  1  high while an iterative op is in progress
- DONE  output  1  one-cycle pulse when ALU_RESULT/ZERO are updated

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (RESET=0 at a rising edge) forces:
  - ALU_RESULT=0, ZERO=1, BUSY=0, DONE=0, FSM=IDLE, counter=0.
  - Reset takes priority over all other inputs.
- Opcodes:
  - 0000 FWD (=OPERAND2), 0001 ADD, 0010 AND, 0011 OR, 0100 SUB (OPERAND1-OPERAND2), 0101 XOR.
  - 0110 SLL, 0111 SRL, 1000 SRA, 1001 ROR (right), 1010 MUL (low WIDTH bits, unsigned).
  - All other codes give result 0 as a single-cycle op.
- Arithmetic: modulo 2^WIDTH, carry discarded.
- FSM states: IDLE, RUN.
- IDLE, START=1, single-cycle op:
  - Result written at this edge; DONE=1 next cycle; stays IDLE.
  - Back-to-back accepts allowed every cycle.
- IDLE, START=1, iterative op:
  - Operands latched and step count S loaded.
  - S = min(OPERAND2, WIDTH) for SLL/SRL/SRA; S = OPERAND2 mod WIDTH for ROR; S = WIDTH for MUL.
  - S=0: behaves as single-cycle, result = OPERAND1.
  - S>0: go to RUN.
- RUN:
  - One shift/rotate step, or one shift-add multiply step, per edge; counter decrements.
  - On the final step: ALU_RESULT and ZERO written, DONE=1 next cycle, return to IDLE.
- Latency: DONE asserts 1+S cycles after the cycle in which START was sampled. BUSY is high for exactly S cycles (the RUN cycles).
- BUSY=0 in the DONE cycle, so a new START is accepted in the DONE cycle.
- START while BUSY=1: ignored, not queued.
- Operand or ALU_OP changes during RUN: no effect.
- SRA fills with OPERAND1[WIDTH-1]; amount >= WIDTH gives all sign bits. SLL/SRL with amount >= WIDTH give 0.
- Reset mid-RUN: aborts the op; no DONE; outputs take reset values.
- ALU_RESULT and ZERO change only at completion or reset.

Optional Feature:
- Macro: ALU_SEQ_OVERFLOW_EN.
- Defined:
  - Adds output OVERFLOW (1 bit), registered with the result, reset 0.
  - ADD/SUB: signed two's-complement overflow.
  - MUL: 1 if the upper WIDTH bits of the full 2*WIDTH product are nonzero, using a 2*WIDTH accumulator.
  - All other ops: 0.
- Undefined: no OVERFLOW port; the MUL accumulator is WIDTH bits.

Decomposition:
- Package alu_seq_pkg holds:
  - 4-bit opcode typedef and named opcode constants.
  - FSM state typedef (IDLE, RUN).
  - Function computing S from opcode/amount/WIDTH.
- Sub-module alu_seq_iter: iterative datapath with shift register, multiply accumulator and step counter, driven by load/step strobes from the top FSM. Single-cycle ops stay in the top level.

Test Plan (WIDTH=8):
- Reset: hold RESET=0 two cycles -> ALU_RESULT=0x00, ZERO=1, BUSY=0, DONE=0.
- Single-cycle ops:
  - ADD 0xF0+0x20 -> 0x10, ZERO=0, DONE one cycle after START.
  - SUB 0x05-0x05 -> 0x00, ZERO=1.
  - Opcode 1111 -> 0x00.
- Shifts and rotate:
  - SLL 0x81 by 3 -> 0x08, BUSY 3 cycles, DONE at START+4.
  - SRA 0x80 by 9 -> 0xFF, DONE at START+9.
  - ROR 0x01 by 9 -> 0x80, DONE at START+2.
  - SRL by 0 -> OPERAND1, DONE at START+1.
- Multiply:
  - MUL 13*11 -> 0x8F, BUSY 8 cycles, DONE at START+9.
  - With ALU_SEQ_OVERFLOW_EN, MUL 16*16 -> 0x00, ZERO=1, OVERFLOW=1; ADD 0x7F+0x01 -> OVERFLOW=1.
- Ignored inputs during RUN: pulse START and change OPERAND1/OPERAND2/ALU_OP during MUL 3*5 -> result 0x0F, single DONE. Back-to-back FWD issued in the DONE cycle is accepted.
- Reset mid-op: RESET=0 in the 4th RUN cycle of MUL -> next cycle BUSY=0, ALU_RESULT=0, ZERO=1, and no DONE ever emitted for the aborted op.
